// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock, MSB first).
// Values above MAX_VAL are not converted; they report overflow and show a blank display.
module bin2bcd_seq #(
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf
);

  localparam int unsigned BIN_W = 14;
  localparam int unsigned BCD_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned NIB_N = BCD_W / 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [BIN_W-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;

  logic [BIN_W-1:0]   w_shift_nxt;
  logic [BCD_W-1:0]   w_scratch_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic               w_ovf_nxt;

  logic               w_over;
  logic [BCD_W-1:0]   w_adj;

  // Each BCD digit that would overflow on doubling gets +3, nibble-local with no carry.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = s;
    for (int i = 0; i < int'(NIB_N); i++) begin
      nib = s[4*i +: 4];
      if (nib >= 4'd5) begin
        nib = nib + 4'd3;
      end
      r[4*i +: 4] = nib;
    end
    return r;
  endfunction

  assign w_over = 32'(bin_in) > MAX_VAL;
  assign w_adj  = add3(r_scratch);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a request is only honoured outside CONV.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (start) begin
          w_state_nxt = w_over ? S_FIN : S_CONV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CONV: begin
        if (r_cnt == CNT_W'(0)) begin
          w_state_nxt = S_FIN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered below.
  always_comb begin
    w_shift_nxt   = r_shift;
    w_scratch_nxt = r_scratch;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_bcd_nxt     = r_bcd;
    w_ovf_nxt     = r_ovf;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (start) begin
          if (w_over) begin
            w_bcd_nxt  = {BCD_W{1'b1}};
            w_ovf_nxt  = 1'b1;
            w_done_nxt = 1'b1;
          end else begin
            w_shift_nxt   = bin_in;
            w_scratch_nxt = '0;
            w_cnt_nxt     = CNT_W'(BIN_W);
            w_busy_nxt    = 1'b1;
          end
        end
      end
      S_CONV: begin
        if (r_cnt != CNT_W'(0)) begin
          w_scratch_nxt = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
          w_shift_nxt   = {r_shift[BIN_W-2:0], 1'b0};
          w_cnt_nxt     = r_cnt - CNT_W'(1);
          w_busy_nxt    = 1'b1;
        end else begin
          w_bcd_nxt  = r_scratch;
          w_ovf_nxt  = 1'b0;
          w_done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_scratch <= w_scratch_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_bcd     <= w_bcd_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule
